// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment controller.
// Coin set, datapath widths and the controller state encoding.
package vend_pkg;

    localparam int PRICE_W  = 4;
    localparam int CREDIT_W = 5;

    localparam logic [PRICE_W-1:0] COIN_1  = 4'd1;
    localparam logic [PRICE_W-1:0] COIN_2  = 4'd2;
    localparam logic [PRICE_W-1:0] COIN_5  = 4'd5;
    localparam logic [PRICE_W-1:0] COIN_10 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_CHANGE
    } vend_state_t;

    function automatic logic is_legal_coin(input logic [PRICE_W-1:0] v);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (v == COIN_1):  ok = 1'b1;
            (v == COIN_2):  ok = 1'b1;
            (v == COIN_5):  ok = 1'b1;
            (v == COIN_10): ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter: clear has priority over enable; expire flags
// the last cycle of the window.
module vend_timeout_ctr #(
    parameter int  TIMEOUT_CYCLES = 1000,
    localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vend_payment_fsm.sv
// Payment controller: latches price, collects coins, drives the
// dispense handshake and pays change or refunds.
module vend_payment_fsm
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PRICE_W-1:0]  price,
    input  logic                select,
    input  logic                coin_valid,
    input  logic [PRICE_W-1:0]  coin_value,
    input  logic                cancel,
    input  logic                dispense_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                dispense_req,
    output logic                change_valid,
    output logic [PRICE_W-1:0]  change_amt,
    output logic                coin_reject,
    output logic                sel_reject
);

    vend_state_t         state_q, state_d;
    logic [PRICE_W-1:0]  price_q, price_d;
    logic [PRICE_W-1:0]  change_q, change_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                busy_q, busy_d;
    logic                req_q, req_d;
    logic                chg_valid_q, chg_valid_d;
    logic [PRICE_W-1:0]  chg_amt_q, chg_amt_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_rej_q, sel_rej_d;

    logic                tmr_clear;
    logic                tmr_en;
    logic                tmr_expire;
    logic                refund;
    logic                coin_ok;
    logic [CREDIT_W-1:0] sum;

    vend_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .enable(tmr_en),
        .expire(tmr_expire)
    );

    assign coin_ok = coin_valid && is_legal_coin(coin_value);
    assign sum     = credit_q + CREDIT_W'(coin_value);

    always_comb begin
        state_d    = state_q;
        price_d    = price_q;
        change_d   = change_q;
        credit_d   = credit_q;
        coin_rej_d = 1'b0;
        sel_rej_d  = 1'b0;
        tmr_clear  = 1'b1;
        tmr_en     = 1'b0;
        refund     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                coin_rej_d = coin_valid;
                if (select) begin
                    if (price != '0) begin
                        state_d  = ST_COLLECT;
                        price_d  = price;
                        credit_d = '0;
                    end else begin
                        sel_rej_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                tmr_clear = 1'b0;
                tmr_en    = 1'b1;
                if (cancel) begin
                    coin_rej_d = coin_valid;
                    refund     = 1'b1;
                end else if (coin_ok) begin
                    tmr_clear = 1'b1;
                    credit_d  = sum;
                    if (sum >= CREDIT_W'(price_q)) begin
                        state_d  = ST_DISPENSE;
                        change_d = PRICE_W'(sum - CREDIT_W'(price_q));
                    end
                end else begin
                    coin_rej_d = coin_valid;
                    refund     = tmr_expire;
                end
                // credit < price <= 15 here, so it fits the change width
                if (refund) begin
                    tmr_clear = 1'b1;
                    credit_d  = '0;
                    change_d  = PRICE_W'(credit_q);
                    state_d   = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                coin_rej_d = coin_valid;
                if (dispense_ack) begin
                    credit_d = '0;
                    state_d  = (change_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_rej_d = coin_valid;
                credit_d   = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        req_d       = (state_d == ST_DISPENSE);
        chg_valid_d = (state_d == ST_CHANGE);
        chg_amt_d   = chg_valid_d ? change_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            price_q     <= '0;
            change_q    <= '0;
            credit_q    <= '0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            chg_valid_q <= 1'b0;
            chg_amt_q   <= '0;
            coin_rej_q  <= 1'b0;
            sel_rej_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            price_q     <= price_d;
            change_q    <= change_d;
            credit_q    <= credit_d;
            busy_q      <= busy_d;
            req_q       <= req_d;
            chg_valid_q <= chg_valid_d;
            chg_amt_q   <= chg_amt_d;
            coin_rej_q  <= coin_rej_d;
            sel_rej_q   <= sel_rej_d;
        end
    end

    assign credit       = credit_q;
    assign busy         = busy_q;
    assign dispense_req = req_q;
    assign change_valid = chg_valid_q;
    assign change_amt   = chg_amt_q;
    assign coin_reject  = coin_rej_q;
    assign sel_reject   = sel_rej_q;

endmodule

// File: tb/tb_vend_payment_fsm.sv
// Self-checking bench: directed scenarios plus random traffic
// against a transaction-level payment model.
module tb_vend_payment_fsm;

    localparam int T = 8;

    logic       clk;
    logic       rst;
    logic [3:0] price;
    logic       select;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       cancel;
    logic       dispense_ack;
    logic [4:0] credit;
    logic       busy;
    logic       dispense_req;
    logic       change_valid;
    logic [3:0] change_amt;
    logic       coin_reject;
    logic       sel_reject;

    int n_chk;
    int n_fail;

    // transaction-level model state
    bit m_active, m_wait, m_chg;
    int m_credit, m_price, m_idle, m_due;
    int e_cv, e_amt, e_crej, e_srej;

    vend_payment_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .price       (price),
        .select      (select),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .cancel      (cancel),
        .dispense_ack(dispense_ack),
        .credit      (credit),
        .busy        (busy),
        .dispense_req(dispense_req),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .coin_reject (coin_reject),
        .sel_reject  (sel_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_wait = 0; m_chg = 0;
        m_credit = 0; m_price = 0; m_idle = 0; m_due = 0;
        e_cv = 0; e_amt = 0; e_crej = 0; e_srej = 0;
    endtask

    task automatic model_step(input bit sel, input int pr, input bit cv,
                              input int cval, input bit can, input bit ack);
        bit legal;
        bit refund_now;
        e_cv = 0; e_amt = 0; e_crej = 0; e_srej = 0;
        if (!m_active) begin
            e_crej = cv;
            if (sel) begin
                if (pr == 0) e_srej = 1;
                else begin
                    m_active = 1; m_price = pr; m_credit = 0; m_idle = 0;
                end
            end
        end else if (m_chg) begin
            e_crej = cv; m_chg = 0; m_active = 0; m_credit = 0;
        end else if (m_wait) begin
            e_crej = cv;
            if (ack) begin
                m_wait = 0; m_credit = 0;
                if (m_due > 0) begin
                    m_chg = 1; e_cv = 1; e_amt = m_due;
                end else m_active = 0;
            end
        end else begin
            legal = cv && (cval inside {1, 2, 5, 10});
            refund_now = 0;
            if (can) begin
                e_crej = cv; refund_now = 1;
            end else if (legal) begin
                m_credit += cval; m_idle = 0;
                if (m_credit >= m_price) begin
                    m_wait = 1; m_due = m_credit - m_price;
                end
            end else begin
                e_crej = cv;
                if (m_idle == T - 1) refund_now = 1;
                else m_idle++;
            end
            if (refund_now) begin
                if (m_credit > 0) begin
                    m_chg = 1; e_cv = 1; e_amt = m_credit;
                end else m_active = 0;
                m_credit = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("credit", credit, m_credit);
        chk("busy", busy, m_active);
        chk("dispense_req", dispense_req, m_wait);
        chk("change_valid", change_valid, e_cv);
        chk("change_amt", change_amt, e_amt);
        chk("coin_reject", coin_reject, e_crej);
        chk("sel_reject", sel_reject, e_srej);
    endtask

    task automatic step(input bit sel, input int pr, input bit cv,
                        input int cval, input bit can, input bit ack);
        select = sel; price = 4'(pr); coin_valid = cv;
        coin_value = 4'(cval); cancel = can; dispense_ack = ack;
        @(posedge clk);
        #1;
        model_step(sel, pr, cv, cval, can, ack);
        compare_all();
        select = 0; price = 0; coin_valid = 0;
        coin_value = 0; cancel = 0; dispense_ack = 0;
    endtask

    task automatic idle();        step(0, 0, 0, 0, 0, 0);  endtask
    task automatic sel(input int p);  step(1, p, 0, 0, 0, 0); endtask
    task automatic coin(input int v); step(0, 0, 1, v, 0, 0); endtask
    task automatic ack();         step(0, 0, 0, 0, 0, 1);  endtask

    initial begin
        int n;
        bit saw_cv;
        int legal_coins[4];
        legal_coins = '{1, 2, 5, 10};
        n_chk = 0; n_fail = 0;
        rst = 1; select = 0; price = 0; coin_valid = 0;
        coin_value = 0; cancel = 0; dispense_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", dispense_req, 0);
        chk("rst_cv", change_valid, 0);
        rst = 0;

        // exact payment
        sel(5);
        coin(2); chk("exact_cr2", credit, 2);
        coin(2); chk("exact_cr4", credit, 4);
        coin(1); chk("exact_cr5", credit, 5);
        chk("exact_req", dispense_req, 1);
        idle();
        ack(); chk("exact_nochg", change_valid, 0);
        chk("exact_idle", busy, 0);
        idle();

        // overpay
        sel(7); coin(5); coin(10);
        chk("over_cr", credit, 15);
        chk("over_req", dispense_req, 1);
        ack(); chk("over_cv", change_valid, 1);
        chk("over_amt", change_amt, 8);
        idle(); chk("over_cv_off", change_valid, 0);

        // illegal coin then cancel with a coin in flight
        sel(9);
        coin(3); chk("ill_rej", coin_reject, 1); chk("ill_cr", credit, 0);
        coin(5); chk("ill_cr5", credit, 5);
        step(0, 0, 1, 2, 1, 0);
        chk("can_rej", coin_reject, 1);
        chk("can_amt", change_amt, 5);
        idle(); chk("can_idle", busy, 0);

        // timeout refund
        sel(4); coin(1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (change_valid) begin n = i; break; end
        end
        chk("to_cycles", n, T);
        chk("to_amt", change_amt, 1);
        idle();

        // silent timeout with no credit
        sel(4);
        n = 0; saw_cv = 0;
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (change_valid) saw_cv = 1;
            if (!busy) begin n = i; break; end
        end
        chk("to_silent_cycles", n, T);
        chk("to_silent_cv", saw_cv, 0);

        // edge cases
        sel(0); chk("sel0_rej", sel_reject, 1); chk("sel0_busy", busy, 0);
        coin(2); chk("idle_coin_rej", coin_reject, 1);
        sel(3); coin(5);
        step(0, 0, 0, 0, 1, 0); chk("disp_cancel_req", dispense_req, 1);
        coin(1); chk("disp_coin_rej", coin_reject, 1);
        ack(); chk("disp_amt", change_amt, 2);
        idle();

        // async reset while dispensing
        sel(2); coin(2);
        #3 rst = 1;
        #1;
        chk("arst_credit", credit, 0);
        chk("arst_req", dispense_req, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        sel(6); chk("arst_sel", busy, 1);
        coin(5); coin(1); ack();
        idle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, cv, cn, ak;
            int p, v;
            s  = ($urandom_range(0, 9) == 0);
            p  = $urandom_range(0, 15);
            cv = ($urandom_range(0, 9) < 3);
            v  = ($urandom_range(0, 1) == 0) ? legal_coins[$urandom_range(0, 3)]
                                             : $urandom_range(0, 15);
            cn = ($urandom_range(0, 39) == 0);
            ak = ($urandom_range(0, 4) == 0);
            step(s, p, cv, v, cn, ak);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
